// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter joining N OBI masters onto one shared bus port, with a
// grant-order ID FIFO that routes each rvalid back to the master that issued it.
package obi_pkg;
  localparam int unsigned NODES = 8;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_rr_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned N_MASTERS = NODES,
  parameter int unsigned ID_DEPTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  obi_req_t  [N_MASTERS-1:0]   masters_req_i,
  output obi_resp_t [N_MASTERS-1:0]   masters_resp_o,
  output obi_req_t                    slave_req_o,
  input  obi_resp_t                   slave_resp_i,
  output logic      [N_MASTERS-1:0]   stall_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned PTR_W = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(ID_DEPTH) + 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] fifo_q [ID_DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;

  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic [IDX_W-1:0] fwd_idx;
  logic             fwd_valid;
  logic [IDX_W-1:0] head_idx;
  logic             full;
  logic             empty;
  logic             handshake;
  logic             pop;

  assign full     = (count_q == CNT_W'(ID_DEPTH));
  assign empty    = (count_q == '0);
  assign head_idx = fifo_q[rd_q];

  // Scan from the far end toward ptr_q so the nearest requester is written last.
  // NOTE: every always_comb output gets a default first, otherwise a path that
  // skips the assignment infers a latch.
  always_comb begin
    cand     = ptr_q;
    any_req  = 1'b0;
    scan_idx = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      scan_idx = IDX_W'((int'(ptr_q) + k) % N_MASTERS);
      if (masters_req_i[scan_idx].req) begin
        cand    = scan_idx;
        any_req = 1'b1;
      end
    end
  end

  // A locked transaction stays pinned to sel_q; a dropped req simply unlocks.
  always_comb begin
    fwd_idx   = cand;
    fwd_valid = any_req && !full;
    if (state_q == LOCKED) begin
      fwd_idx   = sel_q;
      fwd_valid = masters_req_i[sel_q].req;
    end
    if (rst_i) fwd_valid = 1'b0;
  end

  assign handshake = fwd_valid && slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid && !empty && !rst_i;

  always_comb begin
    slave_req_o = '0;
    if (fwd_valid) begin
      slave_req_o     = masters_req_i[fwd_idx];
      slave_req_o.req = 1'b1;
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      masters_resp_o[i]       = '0;
      masters_resp_o[i].rdata = slave_resp_i.rdata;
    end
    masters_resp_o[fwd_idx].gnt     = handshake;
    masters_resp_o[head_idx].rvalid = pop;
    for (int i = 0; i < N_MASTERS; i++) begin
      stall_o[i] = masters_req_i[i].req && !masters_resp_o[i].gnt && !rst_i;
    end
  end

  assign busy_o = !rst_i && (!empty || state_q == LOCKED);
  assign err_o  = !rst_i && slave_resp_i.rvalid && empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fwd_valid && !slave_resp_i.gnt) begin
            state_q <= LOCKED;
            sel_q   <= cand;
          end
        end
        LOCKED: begin
          if (!fwd_valid || slave_resp_i.gnt) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (handshake) begin
        ptr_q <= (fwd_idx == IDX_W'(N_MASTERS - 1)) ? '0 : fwd_idx + IDX_W'(1);
        wr_q  <= (wr_q == PTR_W'(ID_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= (rd_q == PTR_W'(ID_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);

      case ({handshake, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: ID storage is deliberately not reset; count_q/rd_q/wr_q decide which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (handshake) fifo_q[wr_q] <= fwd_idx;
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter: grant order and rvalid routing are scored
// against queues of expected master indices filled as stimulus is applied.
module tb_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int N = NODES;

  logic                clk_i = 1'b0;
  logic                rst_i;
  obi_req_t  [N-1:0]   masters_req;
  obi_resp_t [N-1:0]   masters_resp;
  obi_req_t            slave_req;
  obi_resp_t           slave_resp;
  logic      [N-1:0]   stall;
  logic                busy;
  logic                err;

  int checks = 0;
  int errors = 0;
  int exp_grant[$];
  int exp_rv[$];
  int exp_ptr[6] = '{1, 3, 6, 1, 3, 6};

  obi_rr_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .masters_req_i  (masters_req),
    .masters_resp_o (masters_resp),
    .slave_req_o    (slave_req),
    .slave_resp_i   (slave_resp),
    .stall_o        (stall),
    .busy_o         (busy),
    .err_o          (err)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // -1 when no bit is set, -2 when more than one is set.
  function automatic int who(input logic [N-1:0] v);
    int w = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) w = (w == -1) ? i : -2;
    end
    return w;
  endfunction

  task automatic settle();
    logic [N-1:0] g;
    logic [N-1:0] r;
    int gi;
    int ri;
    #1;
    for (int i = 0; i < N; i++) begin
      g[i] = masters_resp[i].gnt;
      r[i] = masters_resp[i].rvalid;
    end
    gi = who(g);
    ri = who(r);
    if (gi != -1) begin
      if (exp_grant.size() == 0) check("unexpected_gnt", gi, -1);
      else check("gnt_order", gi, exp_grant.pop_front());
    end
    if (ri != -1) begin
      if (exp_rv.size() == 0) check("unexpected_rvalid", ri, -1);
      else check("rvalid_order", ri, exp_rv.pop_front());
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic set_req(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) masters_req[i].req = mask[i];
  endtask

  task automatic set_resp(input logic gnt, input logic rvalid);
    slave_resp.gnt    = gnt;
    slave_resp.rvalid = rvalid;
  endtask

  task automatic expect_grant(input int idx);
    exp_grant.push_back(idx);
    exp_rv.push_back(idx);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      masters_req[i].req   = 1'b0;
      masters_req[i].we    = i[0];
      masters_req[i].be    = 4'hF;
      masters_req[i].addr  = 32'h1000 + 32'(i * 16);
      masters_req[i].wdata = 32'hA000 + 32'(i);
    end
    slave_resp = '0;
    rst_i      = 1'b1;

    // Reset: everything held quiet even with traffic on the inputs.
    advance();
    set_req('1);
    set_resp(1'b1, 1'b1);
    settle();
    check("rst_slave_req", slave_req.req, 0);
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    advance();
    rst_i = 1'b0;
    set_req('0);
    set_resp(1'b0, 1'b0);
    settle();
    check("post_rst_ptr", dut.ptr_q, 0);
    check("post_rst_busy", busy, 0);
    advance();

    // Round robin over masters 0, 2, 5 with gnt tied high; rvalid keeps count at 1.
    foreach (exp_ptr[k]) expect_grant((k % 3 == 0) ? 0 : (k % 3 == 1) ? 2 : 5);
    set_req(8'b0010_0101);
    for (int k = 0; k < 6; k++) begin
      set_resp(1'b1, k != 0);
      step();
      check("rr_ptr", dut.ptr_q, exp_ptr[k]);
    end
    set_req('0);
    set_resp(1'b0, 1'b1);
    step();
    set_resp(1'b0, 1'b0);
    settle();
    check("rr_busy_idle", busy, 0);
    check("rr_queues", exp_grant.size() + exp_rv.size(), 0);
    advance();

    // Master 3 locked while gnt is withheld; master 1 arrives and must wait.
    expect_grant(3);
    expect_grant(1);
    set_req(8'b0000_1000);
    settle();
    check("lock_addr", slave_req.addr, 32'h1030);
    check("lock_stall_first", stall, 8'h08);
    advance();
    check("lock_state", int'(dut.state_q), 1);
    set_req(8'b0000_1010);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("lock_addr_held", slave_req.addr, 32'h1030);
      check("lock_stall", stall, 8'h0A);
      advance();
    end
    set_resp(1'b1, 1'b0);
    settle();
    check("lock_stall_gnt", stall, 8'h02);
    advance();
    set_req(8'b0000_0010);
    step();
    set_req('0);
    set_resp(1'b0, 1'b1);
    step();
    step();
    set_resp(1'b0, 1'b0);
    settle();
    check("lock_queues", exp_grant.size() + exp_rv.size(), 0);
    check("lock_busy_idle", busy, 0);
    advance();

    // FIFO full after four grants; one rvalid reopens it a cycle later.
    for (int m = 2; m <= 6; m++) expect_grant(m);
    set_req(8'b0111_1110);
    set_resp(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 2; k++) begin
      settle();
      check("full_no_req", slave_req.req, 0);
      check("full_stall", stall, 8'h7E);
      advance();
    end
    set_resp(1'b1, 1'b1);
    settle();
    check("full_pop_cycle_req", slave_req.req, 0);
    advance();
    set_resp(1'b1, 1'b0);
    settle();
    check("full_reopen_req", slave_req.req, 1);
    advance();
    set_req('0);
    set_resp(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step();
    set_resp(1'b0, 1'b0);
    settle();
    check("full_queues", exp_grant.size() + exp_rv.size(), 0);
    check("full_busy_idle", busy, 0);
    advance();

    // Grants to 4, 1, 7 then three rvalid pulses return in that order.
    expect_grant(4);
    expect_grant(1);
    expect_grant(7);
    set_resp(1'b1, 1'b0);
    set_req(8'b0001_0000);
    step();
    set_req(8'b0000_0010);
    step();
    set_req(8'b1000_0000);
    step();
    set_req('0);
    slave_resp.rdata = 32'hCAFE_0042;
    set_resp(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("order_busy", busy, 1);
      check("order_rdata_bcast", masters_resp[k].rdata, 32'hCAFE_0042);
      advance();
    end
    set_resp(1'b0, 1'b0);
    settle();
    check("order_busy_fall", busy, 0);
    check("order_queues", exp_grant.size() + exp_rv.size(), 0);
    advance();

    // Stray rvalid with nothing outstanding.
    set_resp(1'b0, 1'b1);
    settle();
    check("stray_err", err, 1);
    advance();
    set_resp(1'b0, 1'b0);
    settle();
    check("stray_err_pulse", err, 0);
    advance();

    // Reset while locked with two IDs outstanding.
    exp_grant.push_back(2);
    exp_grant.push_back(3);
    set_resp(1'b1, 1'b0);
    set_req(8'b0000_0100);
    step();
    set_req(8'b0000_1000);
    step();
    set_req(8'b0001_0000);
    set_resp(1'b0, 1'b0);
    step();
    check("pre_rst_state", int'(dut.state_q), 1);
    check("pre_rst_count", dut.count_q, 2);
    rst_i = 1'b1;
    set_resp(1'b1, 1'b1);
    settle();
    check("mid_rst_slave_req", slave_req.req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    advance();
    rst_i = 1'b0;
    exp_rv.delete();
    set_req('0);
    set_resp(1'b0, 1'b0);
    settle();
    check("rst_state", int'(dut.state_q), 0);
    check("rst_count", dut.count_q, 0);
    check("rst_ptr", dut.ptr_q, 0);
    check("rst_busy_low", busy, 0);
    advance();
    set_resp(1'b0, 1'b1);
    settle();
    check("rst_discard_err", err, 1);
    advance();
    set_resp(1'b0, 1'b0);
    check("final_queues", exp_grant.size() + exp_rv.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
